frame_disassembly: RTL
======================

// Module: frame_disassembly
// PURPOSE
//  Receive side of the MHP byte link. Takes a byte stream of 51-byte MHP frames and unpacks each frame into its fields.
//  Checks the 16-bit SCS checksum.
//  Presents the decoded frame with a one-cycle valid pulse.
//  Sits between the link byte receiver and the command/payload consumers.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max idle cycles between bytes inside a frame before abort (>=2)
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset, synchronous, active-high
//  i_rdata      in   8    received byte
//  i_rvalid     in   1    i_rdata valid this cycle; gaps allowed
//  i_my_addr    in   16   own node address (used only with MHP_ADDR_FILTER_EN)
//  o_dst        out  16   decoded destination
//  o_src        out  16   decoded source
//  o_size       out  16   decoded size
//  o_dir        out  1    decoded direction bit
//  o_type       out  7    decoded type
//  o_payload    out  336  decoded payload, byte 7 in [7:0]
//  o_frame_valid out 1    1-cycle pulse: frame complete, fields stable
//  o_scs_err    out  1    1-cycle pulse with o_frame_valid if checksum mismatch
//  o_timeout    out  1    1-cycle pulse: frame aborted on inter-byte timeout
//  o_busy       out  1    high while a frame is partially received
// BEHAVIOUR
//  Frame, byte index b=0..50, LSB-first fields:
//   b0-1 dst[7:0],dst[15:8]; b2-3 src; b4-5 size; b6 {dir,type[6:0]}; b7-48 payload bytes 0..41; b49 scs[15:8]; b50 scs[7:0].
//  Checksum: scs = sum over b=0..48 of (byte_b << (b mod 4)), truncated to 16 bits. Bytes 49-50 are excluded.
//  Reset: all field outputs 0, all pulses 0, o_busy 0, FSM IDLE, byte counter 0, accumulator 0.
//  FSM IDLE: on i_rvalid, store byte 0, set counter 1, set accumulator to byte 0, go to RECV. o_busy=1 from next cycle.
//  FSM RECV: each i_rvalid byte is stored at the counter index and the counter increments.
//   Bytes 0-48 are added into the accumulator. Bytes 49-50 are shifted into the rx_scs register.
//  On acceptance of byte 50:
//   - next cycle: o_frame_valid=1, o_scs_err=(acc!=rx_scs), field outputs updated on the same edge;
//   - FSM returns to IDLE on the same edge. No dead cycle: a byte in the cycle after byte 50 is byte 0 of the next frame.
//  Field outputs hold their values until the next o_frame_valid. They are updated even when o_scs_err=1.
//  Timeout: a gap counter clears on every accepted byte. If it reaches TIMEOUT_CYCLES in RECV:
//   - o_timeout pulses for 1 cycle, the partial frame is discarded, FSM goes to IDLE;
//   - outputs are unchanged and no o_frame_valid is issued.
//  No timeout is tracked in IDLE.
//  Reset mid-frame discards the partial frame; no pulse is issued.
//  Latency: o_frame_valid is high exactly 1 cycle after byte 50 is accepted.
// CONFIGURATION
//  MHP_ADDR_FILTER_EN defined: when byte 50 completes a frame whose dst is neither i_my_addr nor 0xFFFF:
//   no o_frame_valid, no o_scs_err, outputs unchanged. The FSM still returns to IDLE normally.
//   i_my_addr is sampled when byte 1 is accepted.
//  MHP_ADDR_FILTER_EN undefined: every complete frame is reported and i_my_addr is ignored.
// STRUCTURE
//  Package mhp_pkg:
//   - MHP_FRAME_LEN=51, MHP_PAYLOAD_BYTES=42;
//   - byte offsets OFS_DST=0, OFS_SRC=2, OFS_SIZE=4, OFS_TD=6, OFS_PAY=7, OFS_SCS=49;
//   - MHP_BCAST_ADDR=16'hFFFF;
//   - function mhp_scs_step(acc,byte,idx).
//  Sub-module mhp_scs_accum: clear / add-byte with 2-bit rotating shift, 16-bit result.
//   Shared with the transmit side.
// TESTING
//  1. Frame dst=0x0001, all other bytes 0, b49=0x00, b50=0x01, back-to-back ->
//     o_frame_valid 1 cycle after b50, o_dst=0x0001, o_scs_err=0.
//  2. Same frame with b50=0x02 -> o_frame_valid=1 and o_scs_err=1, o_dst=0x0001.
//  3. Frame A immediately followed by frame B (no gap), B with src=0xBEEF ->
//     two o_frame_valid pulses 51 cycles apart, second has o_src=0xBEEF.
//  4. Stop after byte 20 for TIMEOUT_CYCLES cycles ->
//     o_timeout pulse, no o_frame_valid; a following good frame decodes correctly.
//  5. Random gaps (i_rvalid 50%) with type=0x55, dir=1, payload byte0=0xA5 ->
//     o_type=0x55, o_dir=1, o_payload[7:0]=0xA5.
//  6. With MHP_ADDR_FILTER_EN, i_my_addr=0x0010:
//     dst=0x0011 -> no pulse; dst=0xFFFF -> pulse; dst=0x0010 -> pulse.

Source files
------------

// File: rtl/mhp_pkg.sv
// Shared MHP link constants and the SCS checksum step used by both link directions.
// Consumers: mhp_scs_accum, frame_disassembly (optional MHP_ADDR_FILTER_EN lives in the top).
package mhp_pkg;

    localparam int MHP_FRAME_LEN     = 51;
    localparam int MHP_PAYLOAD_BYTES = 42;

    localparam int OFS_DST  = 0;
    localparam int OFS_SRC  = 2;
    localparam int OFS_SIZE = 4;
    localparam int OFS_TD   = 6;
    localparam int OFS_PAY  = 7;
    localparam int OFS_SCS  = 49;

    localparam logic [15:0] MHP_BCAST_ADDR = 16'hFFFF;

    // Each byte is weighted by 1, 2, 4 or 8 depending on its position modulo 4.
    function automatic logic [15:0] mhp_scs_step(input logic [15:0] acc,
                                                 input logic [7:0]  data,
                                                 input logic [1:0]  idx);
        return acc + ({8'h00, data} << idx);
    endfunction

endpackage

// File: rtl/mhp_scs_accum.sv
// SCS checksum accumulator: clear and/or add one byte per cycle with a rotating 2-bit weight.
// Clear and add in the same cycle loads the byte as the first term of a new sum.
module mhp_scs_accum
    import mhp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        add_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] acc_o
);

    logic [15:0] acc_q, acc_d;
    logic [1:0]  sh_q, sh_d;

    always_comb begin
        acc_d = acc_q;
        sh_d  = sh_q;
        if (clr_i) begin
            acc_d = 16'h0000;
            sh_d  = 2'd0;
        end
        if (add_i) begin
            acc_d = mhp_scs_step(acc_d, byte_i, sh_d);
            sh_d  = sh_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 16'h0000;
            sh_q  <= 2'd0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/frame_disassembly.sv
// MHP receive path: collects 51-byte frames, checks SCS, publishes decoded fields with a valid pulse.
// Optional MHP_ADDR_FILTER_EN drops frames not addressed to i_my_addr or broadcast.
module frame_disassembly
    import mhp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     i_rdata,
    input  logic                           i_rvalid,
    input  logic [15:0]                    i_my_addr,
    output logic [15:0]                    o_dst,
    output logic [15:0]                    o_src,
    output logic [15:0]                    o_size,
    output logic                           o_dir,
    output logic [6:0]                     o_type,
    output logic [8*MHP_PAYLOAD_BYTES-1:0] o_payload,
    output logic                           o_frame_valid,
    output logic                           o_scs_err,
    output logic                           o_timeout,
    output logic                           o_busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam int              GW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0]   GAP_LIM  = GW'(TIMEOUT_CYCLES);
    localparam logic [5:0]      CNT_SCS  = 6'(OFS_SCS);
    localparam logic [5:0]      CNT_LAST = 6'(MHP_FRAME_LEN - 1);

    logic [0:0]    state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    rx_scs_q, rx_scs_d;
    logic          frame_valid_q, frame_valid_d;
    logic          scs_err_q, scs_err_d;
    logic          timeout_q, timeout_d;

    logic [15:0]                    dst_q, src_q, size_q;
    logic [7:0]                     td_q;
    logic [8*MHP_PAYLOAD_BYTES-1:0] pay_q;

    // Bytes 0..48 only; the two SCS bytes never need storing.
    logic [7:0] buf_q [0:OFS_SCS-1];
    logic       buf_we;
    logic [5:0] buf_idx;

    logic        acc_clr, acc_add, load, addr_ok;
    logic [15:0] acc;
    logic [15:0] dst_rx, src_rx, size_rx;
    logic [8*MHP_PAYLOAD_BYTES-1:0] pay_rx;

    mhp_scs_accum u_scs (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (acc_clr),
        .add_i  (acc_add),
        .byte_i (i_rdata),
        .acc_o  (acc)
    );

    assign dst_rx  = {buf_q[OFS_DST+1],  buf_q[OFS_DST]};
    assign src_rx  = {buf_q[OFS_SRC+1],  buf_q[OFS_SRC]};
    assign size_rx = {buf_q[OFS_SIZE+1], buf_q[OFS_SIZE]};

    for (genvar gi = 0; gi < MHP_PAYLOAD_BYTES; gi++) begin : g_pay
        assign pay_rx[8*gi +: 8] = buf_q[OFS_PAY+gi];
    end

`ifdef MHP_ADDR_FILTER_EN
    logic [15:0] my_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            my_addr_q <= 16'h0000;
        end else if (state_q == S_RECV && i_rvalid && cnt_q == 6'd1) begin
            my_addr_q <= i_my_addr;
        end
    end

    assign addr_ok = (dst_rx == my_addr_q) || (dst_rx == MHP_BCAST_ADDR);
`else
    logic unused_my_addr;
    assign unused_my_addr = ^i_my_addr;
    assign addr_ok        = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        rx_scs_d      = rx_scs_q;
        frame_valid_d = 1'b0;
        scs_err_d     = 1'b0;
        timeout_d     = 1'b0;
        acc_clr       = 1'b0;
        acc_add       = 1'b0;
        buf_we        = 1'b0;
        buf_idx       = cnt_q;
        load          = 1'b0;
        case (state_q)
            S_IDLE: begin
                gap_d   = '0;
                buf_idx = 6'd0;
                if (i_rvalid) begin
                    acc_clr = 1'b1;
                    acc_add = 1'b1;
                    buf_we  = 1'b1;
                    cnt_d   = 6'd1;
                    state_d = S_RECV;
                end
            end
            default: begin
                if (i_rvalid) begin
                    gap_d = '0;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q < CNT_SCS) begin
                        buf_we  = 1'b1;
                        acc_add = 1'b1;
                    end else if (cnt_q == CNT_SCS) begin
                        rx_scs_d = i_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        // Low SCS byte arrives live; compare without waiting a cycle.
                        state_d = S_IDLE;
                        cnt_d   = 6'd0;
                        if (addr_ok) begin
                            load          = 1'b1;
                            frame_valid_d = 1'b1;
                            scs_err_d     = (acc != {rx_scs_q, i_rdata});
                        end
                    end
                end else if (gap_q + GW'(1) == GAP_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                    cnt_d     = 6'd0;
                    gap_d     = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_idx] <= i_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 6'd0;
            gap_q         <= '0;
            rx_scs_q      <= 8'h00;
            frame_valid_q <= 1'b0;
            scs_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
            dst_q         <= 16'h0000;
            src_q         <= 16'h0000;
            size_q        <= 16'h0000;
            td_q          <= 8'h00;
            pay_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            rx_scs_q      <= rx_scs_d;
            frame_valid_q <= frame_valid_d;
            scs_err_q     <= scs_err_d;
            timeout_q     <= timeout_d;
            if (load) begin
                dst_q  <= dst_rx;
                src_q  <= src_rx;
                size_q <= size_rx;
                td_q   <= buf_q[OFS_TD];
                pay_q  <= pay_rx;
            end
        end
    end

    assign o_dst         = dst_q;
    assign o_src         = src_q;
    assign o_size        = size_q;
    assign o_dir         = td_q[7];
    assign o_type        = td_q[6:0];
    assign o_payload     = pay_q;
    assign o_frame_valid = frame_valid_q;
    assign o_scs_err     = scs_err_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = (state_q == S_RECV);

endmodule
